// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-channel round-robin arbiter.
//   N_CH      : number of arbitrated channels
//   ch_idx_t  : channel index type
//   next_idx  : successor of a channel index, wrapping 3 -> 0
package rr_arb_pkg;

  localparam int unsigned N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  function automatic ch_idx_t next_idx(ch_idx_t idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin grant for four requesters.
// The search starts at the channel after ptr and wraps around,
// so ptr itself has the lowest priority.
//   req       : per-channel request
//   ptr       : last granted channel
//   grant_vld : at least one request is present
//   grant_idx : winning channel, valid only when grant_vld is set
module rr_grant_4
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  output logic            grant_vld,
  output ch_idx_t         grant_idx
);

  ch_idx_t         start;
  logic [N_CH-1:0] req_rot;
  ch_idx_t         pick;

  assign start = next_idx(ptr);

  // Rotate so that bit 0 is the highest-priority channel.
  always_comb begin
    req_rot = '0;
    for (int k = 0; k < N_CH; k++) begin
      req_rot[k] = req[start + ch_idx_t'(k)];
    end
  end

  // Fixed priority, lowest rotated position wins.
  always_comb begin
    pick = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick = ch_idx_t'(k);
      end
    end
  end

  assign grant_vld = |req;
  // Undo the rotation.
  assign grant_idx = start + pick;

endmodule

// File: rtl/rr_arb_mux_4.sv
// Four-channel round-robin arbitrating selector with a one-entry output register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : per-channel handshake (in_ready is one-hot or zero)
//   in_data0..in_data3  : channel payloads
//   out_valid/out_ready : output handshake
//   out_data, out_sel   : registered payload and the channel index it came from
module rr_arb_mux_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  ch_idx_t        ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;
  ch_idx_t        sel_q, sel_d;

  logic           grant_vld;
  ch_idx_t        grant_idx;
  logic           load_en;
  logic           xfer;
  logic [W-1:0]   grant_data;
  logic [W-1:0]   in_data_arr [N_CH];

  assign in_data_arr[0] = in_data0;
  assign in_data_arr[1] = in_data1;
  assign in_data_arr[2] = in_data2;
  assign in_data_arr[3] = in_data3;

  rr_grant_4 u_grant (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Register can take a word when empty or when it is being drained this cycle.
  assign load_en = !valid_q || out_ready;
  // in_ready depends only on in_valid, ptr, out_valid and out_ready, never on data.
  assign xfer     = grant_vld && load_en && !rst;
  assign in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    grant_data = in_data_arr[grant_idx];
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      ptr_d   = grant_idx;
      valid_d = 1'b1;
      data_d  = grant_data;
      sel_d   = grant_idx;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ptr resets to 3 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Producer contract: a pending request stays up with stable data until accepted.
  for (genvar i = 0; i < N_CH; i++) begin : g_contract
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (in_valid[i] && !in_ready[i]) |=> (in_valid[i] && $stable(in_data_arr[i])));
  end

endmodule

// File: tb/tb_rr_arb_mux_4.sv
module tb_rr_arb_mux_4;

  localparam int W = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d [4];
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [1:0] m_ptr;
  bit         m_full;
  bit         m_load;
  logic [3:0] m_ready;
  word_t      sb [$];
  word_t      w;

  rr_arb_mux_4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_data2  (d[2]),
    .in_data3  (d[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Plain search order ptr+1, ptr+2, ptr+3, ptr.
  function automatic void m_grant(input logic [3:0] v, input logic [1:0] p,
                                  output bit gv, output logic [1:0] gi);
    gv = 1'b0;
    gi = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] c;
      c = p + 2'(k);
      if (!gv && v[c]) begin
        gv = 1'b1;
        gi = c;
      end
    end
  endfunction

  // Drive one cycle of inputs (at negedge), predict in_ready and the next state.
  task automatic apply(input logic r, input logic [3:0] v, input logic orr);
    bit         gv;
    logic [1:0] gi;
    bit         le;
    rst       = r;
    in_valid  = v;
    out_ready = orr;
    #1;
    m_grant(v, m_ptr, gv, gi);
    le      = !m_full || orr;
    m_load  = !r && gv && le;
    m_ready = m_load ? (4'b0001 << gi) : 4'b0000;
    if (r) begin
      m_ptr  = 2'd3;
      m_full = 1'b0;
      sb.delete();
    end else if (m_load) begin
      sb.push_back('{sel: gi, data: d[gi]});
      m_ptr  = gi;
      m_full = 1'b1;
    end else if (m_full && orr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 4'b0000, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 4'b1111, 1'b1);
      total++;
      if (in_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_in_ready c%0d got=%b want=0000", c, in_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL reset_out_valid c%0d got=%b want=0", c, out_valid);
      end
      total++;
      if (out_data !== '0) begin
        bad++; $display("FAIL reset_out_data c%0d got=%h want=0", c, out_data);
      end
      total++;
      if (out_sel !== 2'd0) begin
        bad++; $display("FAIL reset_out_sel c%0d got=%0d want=0", c, out_sel);
      end
    end
    apply(1'b0, 4'b1111, 1'b1);
    total++;
    if (in_ready !== 4'b0001 || in_ready !== m_ready) begin
      bad++; $display("FAIL reset_first_ready got=%b want=0001 model=%b", in_ready, m_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== m_full) begin
      bad++; $display("FAIL reset_first_valid got=%b want=%b", out_valid, m_full);
    end
    if (m_load) begin
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL reset_first_sb empty");
      end else begin
        w = sb.pop_front();
        if (out_sel !== w.sel || out_data !== w.data) begin
          bad++; $display("FAIL reset_first_word got=%0d/%h want=%0d/%h",
                          out_sel, out_data, w.sel, w.data);
        end
      end
    end
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d[2] = 4'(5 + k);
      apply(1'b0, 4'b0100, 1'b1);
      total++;
      if (in_ready !== 4'b0100 || in_ready !== m_ready) begin
        bad++; $display("FAIL single_ready k%0d got=%b want=0100 model=%b", k, in_ready, m_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_valid !== m_full) begin
        bad++; $display("FAIL single_valid k%0d got=%b want=1", k, out_valid);
      end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL single_sb k%0d empty", k);
      end else begin
        w = sb.pop_front();
        if (out_sel !== 2'd2 || out_data !== 4'(5 + k) || out_sel !== w.sel ||
            out_data !== w.data) begin
          bad++; $display("FAIL single_word k%0d got=%0d/%h want=2/%h",
                          k, out_sel, out_data, 4'(5 + k));
        end
      end
    end
    apply(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain got=%b want=0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]   exp_sel  [5];
    logic [W-1:0] exp_data [5];
    exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'b1111, 1'b1);
      total++;
      if (in_ready !== m_ready) begin
        bad++; $display("FAIL cont_ready k%0d got=%b want=%b", k, in_ready, m_ready);
      end
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL cont_sb k%0d empty", k);
      end else begin
        w = sb.pop_front();
        if (out_valid !== 1'b1 || out_sel !== exp_sel[k] || out_data !== exp_data[k] ||
            out_sel !== w.sel || out_data !== w.data) begin
          bad++; $display("FAIL cont_word k%0d got=%b/%0d/%h want=1/%0d/%h",
                          k, out_valid, out_sel, out_data, exp_sel[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 4'b1111, 1'b1);
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL bp_fill_sb k%0d empty", k);
      end else begin
        w = sb.pop_front();
        if (out_sel !== w.sel || out_data !== w.data) begin
          bad++; $display("FAIL bp_fill k%0d got=%0d/%h want=%0d/%h",
                          k, out_sel, out_data, w.sel, w.data);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 4'b1111, 1'b0);
      total++;
      if (in_ready !== 4'b0000 || in_ready !== m_ready) begin
        bad++; $display("FAIL bp_ready c%0d got=%b want=0000", c, in_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'hb || out_sel !== 2'd1) begin
        bad++; $display("FAIL bp_hold c%0d got=%b/%0d/%h want=1/1/b",
                        c, out_valid, out_sel, out_data);
      end
    end
    apply(1'b0, 4'b1111, 1'b1);
    total++;
    if (in_ready !== 4'b0100 || in_ready !== m_ready) begin
      bad++; $display("FAIL bp_release_ready got=%b want=0100", in_ready);
    end
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL bp_release_sb empty");
    end else begin
      w = sb.pop_front();
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== w.data) begin
        bad++; $display("FAIL bp_release_word got=%b/%0d/%h want=1/2/%h",
                        out_valid, out_sel, out_data, w.data);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    logic [1:0] exp_sel [3];
    exp_sel = '{2'd3, 2'd0, 2'd3};
    d[0] = 4'h1; d[3] = 4'h9;
    do_reset();
    apply(1'b0, 4'b0001, 1'b1);  // leaves ptr at 0
    @(negedge clk);
    if (sb.size() != 0) w = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b1001, 1'b1);
      total++;
      if (in_ready !== (4'b0001 << exp_sel[k]) || in_ready !== m_ready) begin
        bad++; $display("FAIL sparse_ready k%0d got=%b model=%b", k, in_ready, m_ready);
      end
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL sparse_sb k%0d empty", k);
      end else begin
        w = sb.pop_front();
        if (out_sel !== exp_sel[k] || out_data !== w.data) begin
          bad++; $display("FAIL sparse_word k%0d got=%0d/%h want=%0d/%h",
                          k, out_sel, out_data, exp_sel[k], w.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    d[0] = 4'h3; d[1] = 4'h4;
    do_reset();
    apply(1'b0, 4'b0001, 1'b1);  // ptr to 0, so channel 1 would win next without reset
    @(negedge clk);
    if (sb.size() != 0) w = sb.pop_front();
    apply(1'b0, 4'b0010, 1'b0);
    @(negedge clk);
    apply(1'b1, 4'b0011, 1'b0);
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL mid_rst_ready got=%b want=0000", in_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid);
    end
    apply(1'b0, 4'b0011, 1'b1);
    total++;
    if (in_ready !== 4'b0001 || in_ready !== m_ready) begin
      bad++; $display("FAIL mid_after_ready got=%b want=0001", in_ready);
    end
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL mid_after_sb empty");
    end else begin
      w = sb.pop_front();
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h3 || out_data !== w.data) begin
        bad++; $display("FAIL mid_after_word got=%b/%0d/%h want=1/0/3",
                        out_valid, out_sel, out_data);
      end
    end
    apply(1'b0, 4'b0011, 1'b1);
    total++;
    if (in_ready !== 4'b0010 || in_ready !== m_ready) begin
      bad++; $display("FAIL mid_next_ready got=%b want=0010", in_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    m_ptr     = 2'd3;
    m_full    = 1'b0;
    m_load    = 1'b0;
    m_ready   = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = '0;
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_4.md
# rr_arb_mux_4

Four-channel round-robin arbitrating selector with valid/ready handshakes. It sits directly upstream of the 4:1 data mux stage, between four independent W-bit producers and one consumer. Each cycle it chooses a requesting channel fairly, accepts that channel's word, and presents it in a one-entry output register. It also emits the 2-bit channel index as the select for downstream routing.

## Interface

Parameters:
- W, default 4: data width of every channel.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 4: per-channel request. Bit i belongs to channel i.
- in_data0 .. in_data3, input, W each: channel payloads.
- in_ready, output, 4: per-channel accept, one-hot or zero.
- out_valid, output, 1: output register holds a word.
- out_data, output, W: registered payload.
- out_sel, output, 2: index of the channel that supplied out_data.
- out_ready, input, 1: consumer accept.

## Operation

Output register:
- The register is either EMPTY (out_valid=0) or FULL (out_valid=1).
- load_en = !out_valid || out_ready.

Arbitration:
- ptr (2 bits) holds the last granted index.
- The search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4, with wrap 3→0.
- grant is the first index in that order with in_valid set. If in_valid is all zero, there is no grant.

in_ready:
- in_ready[grant] = load_en.
- Every other bit of in_ready is 0.
- in_ready is 0 whenever there is no grant or rst=1.

Transfer:
- An input transfer occurs when in_valid[i] && in_ready[i].
- On that edge: out_data ← in_data[i], out_sel ← i, ptr ← i, out_valid ← 1.

Pop:
- A pop occurs when out_valid && out_ready.
- If there is a pop and no input transfer on the same edge, out_valid ← 0. out_data and out_sel keep their last value.

Simultaneous pop and transfer:
- The register is replaced in the same cycle and out_valid stays 1.
- This gives a throughput of one word per cycle.

Backpressure:
- With out_valid=1 and out_ready=0, all in_ready bits are 0.
- out_data, out_sel and ptr hold.

Fairness:
- ptr advances only on an accepted transfer.
- A channel that keeps in_valid asserted is granted within at most 4 transfers.

Producer contract (checked by assertion, not by logic):
- Once in_valid[i] is raised, it stays high, with stable data, until accepted.

## Timing

Reset state, held for as long as rst=1:
- out_valid=0, out_data=0, out_sel=0, ptr=3, so channel 0 has first priority.
- in_ready=4'b0000.

Reset mid-operation:
- Any held word is discarded.
- No transfer is accepted on a cycle where rst=1.

Latency and paths:
- Input handshake to out_valid: 1 cycle.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready. No path goes from in_data to in_ready.
- out_* are registered outputs only.

## Structure

Shared package rr_arb_pkg:
- Parameter N_CH = 4.
- Type ch_idx_t as logic [1:0].
- Function next_idx(ch_idx_t): increment mod 4.

Sub-module rr_grant_4 (combinational):
- Inputs: req[3:0], ptr.
- Outputs: grant_vld, grant_idx.
- Implemented as a rotate, fixed-priority pick, then unrotate.

Top level:
- Holds ptr and the output register.
- Muxes in_data by grant_idx.

Target size: about 150 RTL lines.

## Test plan

- **Reset:** drive rst=1 for 2 cycles with in_valid=4'b1111. Require out_valid=0, out_data=0, out_sel=0, in_ready=0. In the first cycle after rst, in_ready=4'b0001.
- **Single channel stream:** only channel 2 valid, data 'h5,'h6,'h7, out_ready=1. Require a word every cycle, out_sel=2, out_data 5,6,7 each one cycle after its handshake.
- **Full contention:** in_valid=4'b1111 held, data 'ha,'hb,'hc,'hd, out_ready=1. Require out_sel sequence 0,1,2,3,0 and out_data a,b,c,d,a.
- **Backpressure:** while FULL with out_data='hb, hold out_ready=0 for 3 cycles. Require in_ready=0 and out_data='hb, out_sel=1 stable. Release it and the next grant is channel 2.
- **Sparse wrap:** in_valid=4'b1001 with ptr=0. Require grant of channel 3, then channel 0, then channel 3.
- **Reset mid-operation:** assert rst while FULL with out_ready=0. Require out_valid=0 and ptr=3 on the next edge. After release, channel 0 wins over channel 1 when both are valid.
